// File: rtl/comms_pkg.sv
// comms_pkg
// Definitions shared by the UART transmit arbiter and its round-robin picker.
// It holds the sequencer state encoding, the default header tag nibble, the
// length of the post-launch guard, and a helper that sizes requester-index
// fields.
package comms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no owner, arbitrating
        ST_HDR  = 2'd1,  // header byte queued for launch
        ST_PAY  = 2'd2,  // waiting for the owner's next payload byte
        ST_WAIT = 2'd3   // a byte is in flight on the UART
    } arb_state_t;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // The strobe cycle plus the UART's registered tx_running rise: tx_ready
    // cannot be trusted during this window after a launch.
    localparam logic [1:0] GUARD_CYCLES = 2'd2;

    // Width of an index into n requesters. It is never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. The search starts one index above
// last_grant and wraps modulo NUM_REQ, so the most recent owner comes last.
// Ports:
//   req_valid  in  NUM_REQ  requesters currently asking
//   last_grant in  IDX_W    index of the previous owner
//   pick_gnt   out NUM_REQ  one-hot winner, or 0 when nobody asks
//   pick_idx   out IDX_W    binary index of the winner
//   pick_any   out 1        at least one requester is asking
module rr_arbiter
    import comms_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] pick_gnt,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_any
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk candidates last_grant+1 .. last_grant+NUM_REQ and keep the first valid one.
    always_comb begin
        pick_gnt = {NUM_REQ{1'b0}};
        pick_idx = {IDX_W{1'b0}};
        pick_any = 1'b0;
        sum_s    = {(IDX_W + 1){1'b0}};
        cand_s   = {IDX_W{1'b0}};
        hit_s    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum_s  = {1'b0, last_grant} + (IDX_W + 1)'(i);
            // last_grant < NUM_REQ and i <= NUM_REQ, so one subtraction is enough to wrap.
            cand_s = (sum_s >= NUM_REQ_W) ? IDX_W'(sum_s - NUM_REQ_W) : IDX_W'(sum_s);
            hit_s  = !pick_any && req_valid[cand_s];
            pick_gnt[cand_s] = pick_gnt[cand_s] | hit_s;
            pick_idx = hit_s ? cand_s : pick_idx;
            pick_any = pick_any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte-stream requesters. Ownership
// is granted round-robin and is held for a whole packet. Each packet goes out
// as the header {HDR_TAG, id} followed by the owner's bytes up to req_last.
// Only one byte is in flight at a time. An owner that withholds valid for
// TIMEOUT UART-ready cycles mid-packet is dropped, and abort pulses.
// Ports:
//   clock, reset             system clock; synchronous active-low reset
//   req_data/valid/last      per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                combinational accept, owner only, while in PAY
//   grant                    one-hot owner, 0 when idle
//   uart_tx_ready            UART transmitter idle
//   uart_data_in(_valid)     registered byte and its one-cycle launch strobe
//   busy                     a packet is in progress
//   abort                    one-cycle pulse when a packet is dropped
module uart_tx_arbiter
    import comms_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT,
    parameter int         TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 uart_tx_ready,
    output logic [7:0]           uart_data_in,
    output logic                 uart_data_in_valid,
    output logic                 busy,
    output logic                 abort
);

    localparam int               IDX_W   = id_width(NUM_REQ);
    localparam int               TMO_W   = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    arb_state_t         state_r, state_n;
    logic [NUM_REQ-1:0] grant_r, grant_n;
    logic [IDX_W-1:0]   gid_r, gid_n;
    logic [IDX_W-1:0]   last_grant_r, last_grant_n;
    logic [7:0]         data_r, data_n;
    logic               dvalid_r, dvalid_n;
    logic               pkt_last_r, pkt_last_n;
    logic [TMO_W-1:0]   tmo_r, tmo_n;
    logic [1:0]         guard_r, guard_n;
    logic               abort_r, abort_n;
    logic               busy_r;

    logic [NUM_REQ-1:0] pick_gnt_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic [7:0]         g_data_s;
    logic [7:0]         hdr_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant_r),
        .pick_gnt   (pick_gnt_s),
        .pick_idx   (pick_idx_s),
        .pick_any   (pick_any_s)
    );

    // The owner's stream, selected by the latched grant index.
    assign g_valid_s = req_valid[gid_r];
    assign g_last_s  = req_last[gid_r];
    assign g_data_s  = req_data[{gid_r, 3'b000} +: 8];
    assign hdr_s     = {HDR_TAG, 4'(gid_r)};

    // Accept is combinational so that a byte moves in the same cycle the UART is idle.
    assign req_ready = (state_r == ST_PAY && uart_tx_ready) ? grant_r : {NUM_REQ{1'b0}};

    assign grant              = grant_r;
    assign uart_data_in       = data_r;
    assign uart_data_in_valid = dvalid_r;
    assign busy               = busy_r;
    assign abort              = abort_r;

    // Next-state and next-datapath decode of the packet sequencer.
    always_comb begin
        state_n      = state_r;
        grant_n      = grant_r;
        gid_n        = gid_r;
        last_grant_n = last_grant_r;
        data_n       = data_r;
        dvalid_n     = 1'b0;
        pkt_last_n   = pkt_last_r;
        tmo_n        = tmo_r;
        guard_n      = guard_r;
        abort_n      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tmo_n = {TMO_W{1'b0}};
                if (pick_any_s) begin
                    grant_n = pick_gnt_s;
                    gid_n   = pick_idx_s;
                    state_n = ST_HDR;
                end else begin
                    grant_n = {NUM_REQ{1'b0}};
                end
            end
            ST_HDR: begin
                if (uart_tx_ready) begin
                    data_n     = hdr_s;
                    dvalid_n   = 1'b1;
                    pkt_last_n = 1'b0;
                    guard_n    = 2'd0;
                    state_n    = ST_WAIT;
                end else begin
                    state_n = ST_HDR;
                end
            end
            ST_PAY: begin
                if (uart_tx_ready && g_valid_s) begin
                    data_n     = g_data_s;
                    dvalid_n   = 1'b1;
                    pkt_last_n = g_last_s;
                    tmo_n      = {TMO_W{1'b0}};
                    guard_n    = 2'd0;
                    state_n    = ST_WAIT;
                end else if (uart_tx_ready) begin
                    // Only count starvation the requester causes, not UART/CTS back-pressure.
                    if (tmo_r == TMO_MAX) begin
                        abort_n      = 1'b1;
                        last_grant_n = gid_r;
                        grant_n      = {NUM_REQ{1'b0}};
                        tmo_n        = {TMO_W{1'b0}};
                        state_n      = ST_IDLE;
                    end else begin
                        tmo_n = tmo_r + TMO_W'(1);
                    end
                end else begin
                    state_n = ST_PAY;
                end
            end
            ST_WAIT: begin
                if (guard_r != GUARD_CYCLES) begin
                    guard_n = guard_r + 2'd1;
                end else if (uart_tx_ready) begin
                    if (pkt_last_r) begin
                        last_grant_n = gid_r;
                        grant_n      = {NUM_REQ{1'b0}};
                        state_n      = ST_IDLE;
                    end else begin
                        state_n = ST_PAY;
                    end
                end else begin
                    state_n = ST_WAIT;
                end
            end
            default: begin
                grant_n = {NUM_REQ{1'b0}};
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers. last_grant resets to NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {NUM_REQ{1'b0}};
            gid_r        <= {IDX_W{1'b0}};
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            data_r       <= 8'h00;
            dvalid_r     <= 1'b0;
            pkt_last_r   <= 1'b0;
            tmo_r        <= {TMO_W{1'b0}};
            guard_r      <= 2'd0;
            abort_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            grant_r      <= grant_n;
            gid_r        <= gid_n;
            last_grant_r <= last_grant_n;
            data_r       <= data_n;
            dvalid_r     <= dvalid_n;
            pkt_last_r   <= pkt_last_n;
            tmo_r        <= tmo_n;
            guard_r      <= guard_n;
            abort_r      <= abort_n;
            busy_r       <= (state_n != ST_IDLE);
        end
    end

endmodule
